// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF synchronized, mid-bit sampled, LSB first.
// Bytes are delivered through a valid/ready holding register; framing and overrun errors are pulsed.
module uart_byte_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = ($clog2(CYCLES_PER_BIT) > 9) ? $clog2(CYCLES_PER_BIT) : 9;

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic             byte_done;
    logic             stop_bad;

    logic rx_meta;
    logic rx_s;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        byte_done    = 1'b0;
        stop_bad     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (rx_fall) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_next   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next            = '0;
                    shreg_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A byte completing while the holding register is full and not being drained is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done & rx_valid & ~rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: drives 8N1 frames at 8680 ns/bit and checks
// delivery, framing error, glitch rejection, overrun, mid-frame reset and back-to-back frames.
module tb_uart_byte_rx;

    localparam int BIT_NS = 8680;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests;
    int n_fail;

    int         valid_cyc;
    int         ferr_cyc;
    int         ovr_cyc;
    int         busy_cyc;
    int         acc_cnt;
    logic [7:0] acc_log [0:63];

    int v0, f0, o0, b0, a0;

    uart_byte_rx #(
        .CLK_FREQ (50000000),
        .BAUD_RATE(115200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        valid_cyc = 0;
        ferr_cyc  = 0;
        ovr_cyc   = 0;
        busy_cyc  = 0;
        acc_cnt   = 0;
    end

    // Event recorder sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)  valid_cyc = valid_cyc + 1;
        if (frame_err) ferr_cyc  = ferr_cyc + 1;
        if (overrun)   ovr_cyc   = ovr_cyc + 1;
        if (busy)      busy_cyc  = busy_cyc + 1;
        if (rx_valid && rx_ready) begin
            acc_log[acc_cnt % 64] = rx_data;
            acc_cnt = acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests = n_tests + 1;
        assert (observed === expected) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(BIT_NS);
        end
        uart_rx = stop;
        #(BIT_NS);
        uart_rx = 1'b1;
    endtask

    task automatic snap();
        v0 = valid_cyc;
        f0 = ferr_cyc;
        o0 = ovr_cyc;
        b0 = busy_cyc;
        a0 = acc_cnt;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;

        wait_cycles(5);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_rx_data",   32'(rx_data),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        wait_cycles(20);

        // 1: clean 0xA3 with the consumer ready
        snap();
        send_byte(8'hA3, 1'b1);
        wait_cycles(20);
        check("a3_accepts",   32'(acc_cnt - a0),   32'd1);
        check("a3_data",      32'(acc_log[a0 % 64]), 32'hA3);
        check("a3_valid_cyc", 32'(valid_cyc - v0), 32'd1);
        check("a3_ferr",      32'(ferr_cyc - f0),  32'd0);
        check("a3_ovr",       32'(ovr_cyc - o0),   32'd0);
        check("a3_busy_idle", 32'(busy),           32'd0);

        // 2: stop bit low, then idle, then a good 0x55
        snap();
        send_byte(8'hA3, 1'b0);
        #(BIT_NS);
        check("ferr_pulse",    32'(ferr_cyc - f0),  32'd1);
        check("ferr_no_valid", 32'(valid_cyc - v0), 32'd0);
        check("ferr_no_ovr",   32'(ovr_cyc - o0),   32'd0);
        check("ferr_busy",     32'(busy),           32'd0);
        snap();
        send_byte(8'h55, 1'b1);
        wait_cycles(20);
        check("x55_accepts", 32'(acc_cnt - a0),     32'd1);
        check("x55_data",    32'(acc_log[a0 % 64]), 32'h55);
        check("x55_ferr",    32'(ferr_cyc - f0),    32'd0);

        // 3: 100 ns glitch is rejected after exactly HALF_BIT cycles in START
        snap();
        uart_rx = 1'b0;
        #100;
        uart_rx = 1'b1;
        wait_cycles(300);
        check("glitch_busy_cyc", 32'(busy_cyc - b0),  32'd217);
        check("glitch_busy_now", 32'(busy),           32'd0);
        check("glitch_no_valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch_no_ferr",  32'(ferr_cyc - f0),  32'd0);

        // 4: stalled consumer, back-to-back 0x11 then 0x22
        rx_ready = 1'b0;
        snap();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cycles(20);
        check("ovr_valid_held", 32'(rx_valid),       32'd1);
        check("ovr_data_held",  32'(rx_data),        32'h11);
        check("ovr_pulse",      32'(ovr_cyc - o0),   32'd1);
        check("ovr_no_ferr",    32'(ferr_cyc - f0),  32'd0);
        rx_ready = 1'b1;
        wait_cycles(1);
        check("ovr_drain_valid", 32'(rx_valid),         32'd0);
        check("ovr_drain_data",  32'(acc_log[a0 % 64]), 32'h11);
        check("ovr_drain_cnt",   32'(acc_cnt - a0),     32'd1);

        // 5: reset during data bit 4 with a byte held
        rx_ready = 1'b0;
        send_byte(8'h5A, 1'b1);
        wait_cycles(10);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_data",  32'(rx_data),  32'h5A);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i % 2 == 0);
            #(BIT_NS);
        end
        uart_rx = 1'b1;
        #(BIT_NS / 2);
        check("mid_frame_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid),  32'd0);
        check("midrst_data",  32'(rx_data),   32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_ferr",  32'(frame_err), 32'd0);
        check("midrst_ovr",   32'(overrun),   32'd0);
        uart_rx = 1'b1;
        wait_cycles(3);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        wait_cycles(868);
        check("postrst_busy", 32'(busy), 32'd0);
        snap();
        send_byte(8'h3C, 1'b1);
        wait_cycles(20);
        check("x3c_accepts", 32'(acc_cnt - a0),     32'd1);
        check("x3c_data",    32'(acc_log[a0 % 64]), 32'h3C);

        // 6: 0x00 then 0xFF with no idle gap
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_cycles(20);
        check("b2b_accepts",   32'(acc_cnt - a0),           32'd2);
        check("b2b_first",     32'(acc_log[a0 % 64]),       32'h00);
        check("b2b_second",    32'(acc_log[(a0 + 1) % 64]), 32'hFF);
        check("b2b_valid_cyc", 32'(valid_cyc - v0),         32'd2);
        check("b2b_ferr",      32'(ferr_cyc - f0),          32'd0);
        check("b2b_ovr",       32'(ovr_cyc - o0),           32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
